// File: rtl/cpu_timer_pkg.sv
// Shared definitions for the machine timer: register map, CTRL bit layout and bus states.
package cpu_timer_pkg;

  localparam logic [2:0] TIMER_MTIME_LO = 3'd0;
  localparam logic [2:0] TIMER_MTIME_HI = 3'd1;
  localparam logic [2:0] TIMER_CMP_LO   = 3'd2;
  localparam logic [2:0] TIMER_CMP_HI   = 3'd3;
  localparam logic [2:0] TIMER_CTRL     = 3'd4;
  localparam logic [2:0] TIMER_PRESCALE = 3'd5;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_ARMED_BIT  = 1;
  localparam int CTRL_FIRED_BIT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } busState_t;

  function automatic logic [31:0] packCtrl(input logic enable, input logic armed, input logic fired);
    logic [31:0] value;
    value = 32'd0;
    value[CTRL_ENABLE_BIT] = enable;
    value[CTRL_ARMED_BIT]  = armed;
    value[CTRL_FIRED_BIT]  = fired;
    return value;
  endfunction

endpackage

// File: rtl/cpu_timer_prescaler.sv
// Divides the input clock down to the mtime tick rate; o_tick marks the wrap cycle.
module cpu_timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;

  assign o_tick = i_enable && (r_count == LAST);

  // A clear restarts the tick period even while the timer is disabled.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_tick ? '0 : (r_count + ONE);
    end
  end

endmodule

// File: rtl/cpu_timer.sv
// Memory-mapped mtime/mtimecmp timer producing a one-cycle interrupt pulse for the CSR unit.
module cpu_timer
  import cpu_timer_pkg::*;
#(
  parameter int FREQUENCY = 100000000,
  parameter int TICK_RATE = 1000000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [2:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt
);

  localparam int PRESCALE = FREQUENCY / TICK_RATE;

  generate
    if (PRESCALE < 1) begin : g_badPrescale
      $error("cpu_timer: FREQUENCY / TICK_RATE must be at least 1");
    end
  endgenerate

  busState_t   r_state;
  busState_t   w_stateNext;
  logic        w_access;
  logic        w_write;
  logic        w_read;
  logic        w_mtimeWrite;
  logic        w_cmpLoWrite;
  logic        w_cmpHiWrite;
  logic        w_ctrlWrite;
  logic        w_tick;
  logic        w_match;
  logic        w_fire;
  logic [31:0] w_readData;

  logic [63:0] r_mtime;
  logic [63:0] r_mtimeCmp;
  logic [31:0] r_shadow;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_enable;
  logic        r_armed;
  logic        r_fired;
  logic        r_interrupt;

  // Side effects happen only on the IDLE->ACK step, so a held request acts once.
  always_comb begin
    w_stateNext = r_state;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_request) begin
          w_stateNext = ACK;
          w_access    = 1'b1;
        end
      end
      ACK: begin
        if (!i_request) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  assign w_write      = w_access && i_rw;
  assign w_read       = w_access && !i_rw;
  assign w_mtimeWrite = w_write && ((i_address == TIMER_MTIME_LO) || (i_address == TIMER_MTIME_HI));
  assign w_cmpLoWrite = w_write && (i_address == TIMER_CMP_LO);
  assign w_cmpHiWrite = w_write && (i_address == TIMER_CMP_HI);
  assign w_ctrlWrite  = w_write && (i_address == TIMER_CTRL);

  always_comb begin
    w_readData = 32'd0;
    case (i_address)
      TIMER_MTIME_LO: w_readData = r_mtime[31:0];
      TIMER_MTIME_HI: w_readData = r_shadow;
      TIMER_CMP_LO:   w_readData = r_mtimeCmp[31:0];
      TIMER_CMP_HI:   w_readData = r_mtimeCmp[63:32];
      TIMER_CTRL:     w_readData = packCtrl(r_enable, r_armed, r_fired);
      TIMER_PRESCALE: w_readData = 32'(PRESCALE);
      default:        w_readData = 32'd0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= (w_stateNext == ACK);
      if (w_read) begin
        r_rdata <= w_readData;
      end else if (w_stateNext == IDLE) begin
        r_rdata <= 32'd0;
      end
    end
  end

  // Reading the low half snapshots the high half so a LO-then-HI pair is coherent.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shadow <= 32'd0;
    end else if (w_read && (i_address == TIMER_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  cpu_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (r_enable),
    .i_clear  (w_mtimeWrite),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mtime <= 64'd0;
    end else if (w_write && (i_address == TIMER_MTIME_LO)) begin
      r_mtime[31:0] <= i_wdata;
    end else if (w_write && (i_address == TIMER_MTIME_HI)) begin
      r_mtime[63:32] <= i_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mtimeCmp <= '1;
      r_enable   <= 1'b0;
    end else begin
      if (w_cmpLoWrite) begin
        r_mtimeCmp[31:0] <= i_wdata;
      end
      if (w_cmpHiWrite) begin
        r_mtimeCmp[63:32] <= i_wdata;
      end
      if (w_ctrlWrite) begin
        r_enable <= i_wdata[CTRL_ENABLE_BIT];
      end
    end
  end

  assign w_match = r_armed && (r_mtime >= r_mtimeCmp);
  assign w_fire  = w_match && !w_cmpLoWrite;

  // A CMP_LO write disarms and beats a simultaneous match; only CMP_HI re-arms.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_armed     <= 1'b0;
      r_fired     <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      r_interrupt <= w_fire;
      if (w_cmpLoWrite) begin
        r_armed <= 1'b0;
      end else if (w_cmpHiWrite) begin
        r_armed <= 1'b1;
      end else if (w_match) begin
        r_armed <= 1'b0;
      end
      if (w_fire) begin
        r_fired <= 1'b1;
      end else if (w_ctrlWrite && i_wdata[CTRL_FIRED_BIT]) begin
        r_fired <= 1'b0;
      end
    end
  end

  assign o_rdata     = r_rdata;
  assign o_ready     = r_ready;
  assign o_interrupt = r_interrupt;

endmodule

// File: doc/cpu_timer.md
Name: cpu_timer

Overview:
- Memory-mapped machine timer (mtime/mtimecmp) sitting on the CPU peripheral bus, directly upstream of the CSR unit.
- Produces the single-cycle timer interrupt pulse that drives the CSR unit's i_timer_interrupt input.
- Provides a 64-bit free-running tick counter with a programmable prescaler, a 64-bit compare register and an armed/fired compare mechanism, so one compare match raises exactly one interrupt.

Parameters:
- FREQUENCY, 100000000, input clock frequency in Hz.
- TICK_RATE, 1000000, mtime increment rate in Hz; PRESCALE = FREQUENCY / TICK_RATE, must be >= 1 (elaboration error otherwise).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset: synchronous, active-high.
- i_request  in  1  bus request; held high until o_ready seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  3  word index (register select).
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid while o_ready = 1.
- o_ready  out  1  bus acknowledge.
- o_interrupt  out  1  one-cycle timer interrupt pulse to the CSR unit.

Behaviour:
- Register map by i_address:
  - 0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI.
  - 4 CTRL: bit0 enable, bit1 armed (read-only), bit2 fired (write-1-to-clear).
  - 5 PRESCALE, read-only.
  - 6, 7: read 0, writes ignored.
- Reset values: mtime = 0, mtimecmp = all ones, prescaler count = 0, enable = 0, armed = 0, fired = 0, shadow = 0, o_ready = 0, o_rdata = 0, o_interrupt = 0, bus FSM = IDLE. Reset mid-transaction returns the FSM to IDLE and drops o_ready the next cycle.
- Bus FSM:
  - IDLE: on i_request = 1, perform the access and go to ACK. o_ready = 1 and o_rdata are registered, so latency from request to ready is 1 cycle.
  - ACK: o_ready held 1. When i_request = 0, go to IDLE with o_ready = 0. While in ACK, no further side effects occur even if the request stays high.
  - Each access has its side effect exactly once, on the IDLE->ACK transition.
- 64-bit coherency:
  - Reading MTIME_LO latches mtime[63:32] into the shadow register in the same cycle.
  - Reading MTIME_HI returns the shadow, not live mtime, so LO-then-HI reads form a coherent pair.
- Tick:
  - When enable = 1, the prescaler counts 0..PRESCALE-1. On the wrap cycle, mtime <= mtime + 1 (64-bit, wraps all-ones to 0).
  - When enable = 0, both the prescaler and mtime hold.
- Writes:
  - Writing MTIME_LO or MTIME_HI replaces that half and clears the prescaler to 0. A bus write and a tick in the same cycle: the write wins and the tick is lost.
  - Writing CMP_LO updates the low half and clears armed.
  - Writing CMP_HI updates the high half and sets armed. Software order is LO then HI.
  - Writing CTRL: bit0 -> enable; bit2 = 1 clears fired.
- Compare:
  - match = armed && (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values.
  - When match is true, the next cycle has o_interrupt = 1 for exactly one cycle, armed <= 0 and fired <= 1.
  - No further pulse occurs until software re-arms by writing CMP_HI.
  - Arming with mtimecmp already <= mtime fires on the cycle after the CMP_HI write.
  - If a CMP_LO write and a match occur in the same cycle, the write wins: disarm, no pulse.
- Disabling the timer does not clear armed; the compare remains live against the held mtime.

Decomposition:
- Shared package cpu_timer_pkg:
  - register index constants (TIMER_MTIME_LO ... TIMER_PRESCALE);
  - CTRL bit positions;
  - bus FSM state enum (IDLE, ACK).
- One natural sub-module: cpu_timer_prescaler (counter plus tick strobe, with enable and synchronous clear inputs); the compare, arming and bus logic stay in the top module.

Test Plan:
- Reset, then read CTRL and CMP_HI -> 0x00000000 and 0xFFFFFFFF. o_ready rises exactly 1 cycle after i_request and drops 1 cycle after i_request falls.
- PRESCALE = 4: write CTRL = 1, wait 40 cycles, read MTIME_LO -> 10 (±1). With CTRL = 0 for a further 40 cycles -> value unchanged.
- Write MTIME_HI = 0, MTIME_LO = 0xFFFFFFFE. Then read LO, wait for 2 ticks, read HI -> HI returns 0 (shadow, not the live value of 1).
- Write CMP_LO = 20, CMP_HI = 0, MTIME = 0, enable -> o_interrupt high for exactly 1 cycle when mtime reaches 20. CTRL reads armed = 0, fired = 1. No second pulse within 100 further ticks.
- With mtime = 50, write CMP_LO = 10 then CMP_HI = 0 -> pulse on the cycle after the CMP_HI acknowledge. Writing CTRL = 0x5 then reads fired = 0.
- Assert i_reset while in ACK with armed = 1 -> next cycle o_ready = 0 and armed = 0. No o_interrupt pulse afterwards.
